// File: rtl/host_mem_ctrl.sv
// Line-granular DMA bridge between the miner CPU and the AFU host ports.
// Stages one cache line in a buffer the CPU reads and writes a word at a time.
`timescale 1ns/1ps
module host_mem_ctrl #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_init,
  input  logic [1:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wr_data,
  output logic [WORD_W-1:0] cpu_rd_data,
  output logic              cpu_ready,
  output logic              tx_done,
  output logic              tx_err,
  input  logic              host_rd_ready,
  input  logic              host_wr_ready,
  input  logic [ADDR_W-1:0] address_offset,
  input  logic [LINE_W-1:0] host_data_bus_read_in,
  output logic [LINE_W-1:0] host_data_bus_write_out,
  output logic [ADDR_W-1:0] corrected_address,
  output logic              host_re,
  output logic              host_we,
  output logic              host_rgo,
  output logic              host_wgo
);

  localparam int unsigned WORD_LSB = $clog2(WORD_W / 8);
  localparam int unsigned LINE_LSB = $clog2(LINE_W / 8);
  localparam int unsigned BIT_LSB  = $clog2(WORD_W);
  localparam int unsigned BIT_W    = $clog2(LINE_W);
  localparam int unsigned IDX_W    = BIT_W - BIT_LSB;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_FLUSH = 2'b10;
  localparam logic [1:0] OP_WORD  = 2'b11;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    RD_GO,
    RD_WAIT,
    WR_GO,
    WR_WAIT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [LINE_W-1:0] buffer;
  logic [CNT_W-1:0]  wait_cnt;

  logic              load_addr;
  logic              word_wr;
  logic              line_cap;
  logic              cnt_inc;
  logic              abort;

  logic [IDX_W-1:0]  word_idx;
  logic [BIT_W-1:0]  word_bit;
  logic [ADDR_W-1:0] line_base;
  logic              unused_addr_lsb;

  // Word select and line-aligned address; sub-word byte bits carry no meaning here.
  assign word_idx        = cpu_addr[WORD_LSB +: IDX_W];
  assign word_bit        = {word_idx, BIT_LSB'(0)};
  assign line_base       = {cpu_addr[ADDR_W-1:LINE_LSB], LINE_LSB'(0)};
  assign unused_addr_lsb = ^cpu_addr[WORD_LSB-1:0];

  assign host_data_bus_write_out = buffer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state, DMA handshake strobes and datapath enables.
  always_comb begin
    next_state = state;
    host_re    = 1'b0;
    host_we    = 1'b0;
    load_addr  = 1'b0;
    word_wr    = 1'b0;
    line_cap   = 1'b0;
    cnt_inc    = 1'b0;
    abort      = 1'b0;
    case (state)
      WAIT_INIT: begin
        if (host_init) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        case (cpu_op)
          OP_FETCH: begin
            load_addr  = 1'b1;
            next_state = RD_GO;
          end
          OP_FLUSH: begin
            load_addr  = 1'b1;
            next_state = WR_GO;
          end
          OP_WORD: begin
            word_wr    = 1'b1;
            next_state = DONE;
          end
          default: ;
        endcase
      end
      RD_GO: begin
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (host_rd_ready) begin
          host_re    = 1'b1;
          line_cap   = 1'b1;
          next_state = DONE;
        end else begin
          cnt_inc = 1'b1;
          if (wait_cnt == CNT_LAST) begin
            abort      = 1'b1;
            next_state = IDLE;
          end
        end
      end
      WR_GO: begin
        next_state = WR_WAIT;
      end
      WR_WAIT: begin
        if (host_wr_ready) begin
          host_we    = 1'b1;
          next_state = DONE;
        end else begin
          cnt_inc = 1'b1;
          if (wait_cnt == CNT_LAST) begin
            abort      = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = WAIT_INIT;
      end
    endcase
  end

  // Registered status pulses are derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ready <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      host_rgo  <= 1'b0;
      host_wgo  <= 1'b0;
    end else begin
      cpu_ready <= (next_state == IDLE);
      tx_done   <= (next_state == DONE);
      tx_err    <= abort;
      host_rgo  <= (next_state == RD_GO);
      host_wgo  <= (next_state == WR_GO);
    end
  end

  // Address relocation wraps modulo 2^ADDR_W; the wait counter restarts per op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corrected_address <= '0;
      wait_cnt          <= '0;
    end else if (load_addr) begin
      corrected_address <= address_offset + line_base;
      wait_cnt          <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Line buffer: whole-line capture and CPU word writes live in different states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer      <= '0;
      cpu_rd_data <= '0;
    end else begin
      cpu_rd_data <= buffer[word_bit +: WORD_W];
      if (line_cap) begin
        buffer <= host_data_bus_read_in;
      end else if (word_wr) begin
        buffer[word_bit +: WORD_W] <= cpu_wr_data;
      end
    end
  end

endmodule

// File: doc/host_mem_ctrl.md
# host_mem_ctrl

Cache-line memory controller inside `miner`, sitting directly between the miner CPU and the AFU's DMA-facing `host_*` ports. It turns CPU line-fetch / line-flush requests into single-line DMA read/write transactions, relocating CPU addresses by the software-supplied `address_offset`. It stages each line in a 512-bit line buffer that the CPU accesses one 32-bit word at a time.

## Interface
- `ADDR_W`, 64: host virtual byte address width.
- `LINE_W`, 512: cache line width.
- `WORD_W`, 32: CPU word width.
- `TIMEOUT`, 65535: maximum number of wait cycles for `host_rd_ready` / `host_wr_ready` before abort.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_init`  in  1  MMIO go; enables the block.
- `cpu_op`  in  2  00 none, 01 line fetch, 10 line flush, 11 buffer word write.
- `cpu_addr`  in  ADDR_W  CPU byte address.
- `cpu_wr_data`  in  WORD_W  word to be written by op 11.
- `cpu_rd_data`  out  WORD_W  registered read of buffer word `cpu_addr[5:2]`.
- `cpu_ready`  out  1  op accepted this cycle if `cpu_op != 0`.
- `tx_done`  out  1  one-cycle pulse when an op completes.
- `tx_err`  out  1  one-cycle pulse on a timeout abort.
- `host_rd_ready`  in  1  DMA read data available (`~empty`).
- `host_wr_ready`  in  1  DMA write space available (`~full`).
- `address_offset`  in  ADDR_W  relocation base.
- `host_data_bus_read_in`  in  LINE_W  DMA read data.
- `host_data_bus_write_out`  out  LINE_W  equals the line buffer.
- `corrected_address`  out  ADDR_W  registered DMA address.
- `host_re`, `host_we`, `host_rgo`, `host_wgo`  out  1  DMA strobes.

## Operation
- FSM states: WAIT_INIT, IDLE, RD_GO, RD_WAIT, WR_GO, WR_WAIT, DONE.
- **WAIT_INIT:** `cpu_ready` = 0. When `host_init` = 1, go to IDLE. `host_init` is ignored in every other state.
- **IDLE:** `cpu_ready` = 1. Ops are sampled only here and are not queued; the CPU holds `cpu_op` until it sees `cpu_ready`.
  - **Op 01 or 10 accepted:** register `corrected_address = address_offset + {cpu_addr[63:6], 6'b0}`, modulo 2^64 (wrap is silent; `cpu_addr[5:0]` is ignored). Reset the wait counter. Go to RD_GO (op 01) or WR_GO (op 10).
  - **Op 11 accepted:** `buffer[32i+31:32i] <= cpu_wr_data` with `i = cpu_addr[5:2]`. Go to DONE.
- **RD_GO:** `host_rgo` = 1 for one cycle. Go to RD_WAIT.
- **RD_WAIT:**
  - If `host_rd_ready`: `host_re` = 1 combinationally in the same cycle, the buffer captures `host_data_bus_read_in` on that edge, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, pulse `tx_err` and go to IDLE; the buffer is unchanged.
- **WR_GO:** `host_wgo` = 1 for one cycle. Go to WR_WAIT.
- **WR_WAIT:**
  - If `host_wr_ready`: `host_we` = 1 for one cycle, go to DONE.
  - Otherwise increment the counter, with the same timeout rule as RD_WAIT.
- **DONE:** `tx_done` = 1 for one cycle. Go to IDLE.
- **Word read:** `cpu_rd_data` is updated every cycle, in any state, from `buffer` word `cpu_addr[5:2]`.
- **Buffer writes:** a word write and a fetch capture can never coincide (they happen in different states).

## Timing
- **Reset (async assert, sync release):** state WAIT_INIT. Buffer, `cpu_rd_data`, `corrected_address`, and the counter are 0. All strobes, `cpu_ready`, `tx_done`, and `tx_err` are 0.
- **Reset mid-op:** any in-flight DMA is abandoned with no completion pulse, and `host_init` is required again.
- **Fetch latency**, with accept at cycle 0:
  - `host_rgo` at cycle 1.
  - Earliest `host_re` at cycle 2.
  - `tx_done` at cycle 3.
  - `cpu_ready` again at cycle 4.
  - New data is visible on `cpu_rd_data` at cycle 4.
- **Flush latency:** the same cycle pattern, using `host_wgo`/`host_we`. `host_data_bus_write_out` is stable from accept through `host_we`.
- **Word write:** accept at cycle 0, `tx_done` at cycle 1, readback valid from cycle 2.
- **Strobe exclusivity:** `host_re` and `host_we` are never high at the same time. The buffer-capture edge coincides with `host_re`. `host_we` is never asserted outside WR_WAIT, and `host_re` never outside RD_WAIT.
- **Timeout:** `tx_err` is asserted exactly TIMEOUT cycles after entering a wait state when ready never arrives.

## Test plan
- **Reset/init gating:** drive `rst_n` low, then high, with `cpu_op` = 01 and no `host_init` for 20 cycles. Required: no strobes and `cpu_ready` = 0. Then pulse `host_init`: `cpu_ready` = 1 on the next cycle.
- **Fetch:** `address_offset` = 0x1000, `cpu_addr` = 0x7F, `host_rd_ready` after 3 cycles, data word j = j. Required: `corrected_address` = 0x1040, one `host_rgo`, one `host_re`, one `tx_done`, and `cpu_rd_data` = 5 when `cpu_addr[5:2]` = 5.
- **Word write then flush:** write 0xDEADBEEF to word 15, then flush. Required: `host_data_bus_write_out[511:480]` = 0xDEADBEEF at `host_we`, and exactly one `host_wgo` and one `host_we`.
- **Address wrap:** `address_offset` = 0xFFFF_FFFF_FFFF_FFC0, `cpu_addr` = 0x80. Required: `corrected_address` = 0x40.
- **Timeout:** flush with `host_wr_ready` held at 0 and TIMEOUT = 8. Required: `tx_err` after 8 wait cycles, no `host_we`, no `tx_done`, and the block back in IDLE.
- **Reset mid-fetch:** assert `rst_n` low in RD_WAIT. Required: all outputs 0 immediately, the buffer cleared, and no `tx_done`.
